ecc_io_framer: RTL and testbench
================================

// Module: ecc_io_framer
// PURPOSE
//  Parametrised stream framer between a 64-bit valid/ready host port and a wide point-arithmetic core.
//  Deserialises N_IN_OPS operands of OP_W bits each, sending the most significant word first,
//  then pulses the core start and holds the operands stable. It captures the core result and
//  serialises it back, MSW first, under output backpressure.
//  Successor of the fixed 3x256-in / 4-word-out ed25519 wrapper: adds true input flow control,
//  configurable operand geometry and an explicit core start/done interface.
// PARAMETERS
//  DATA_W    64   host word width
//  OP_W      256  operand width; must be an integer multiple of DATA_W
//  N_IN_OPS  3    operands per job (e.g. scalar M, X, Y)
//  N_OUT_OPS 1    result operands per job
//  derived: WORDS = OP_W/DATA_W; IN_WORDS = N_IN_OPS*WORDS; OUT_WORDS = N_OUT_OPS*WORDS
// PORTS
//  i_clk           in   1                 clock, rising edge
//  i_rst           in   1                 synchronous reset, active-high
//  i_in_valid      in   1                 host input word valid
//  o_in_ready      out  1                 framer accepts input word
//  i_in_data       in   DATA_W            host input word
//  o_out_valid     out  1                 output word valid
//  i_out_ready     in   1                 host accepts output word
//  o_out_data      out  DATA_W            output word
//  o_core_start    out  1                 one-cycle job start pulse
//  o_core_operands out  N_IN_OPS*OP_W     operand 0 (first received) in the MSBs
//  i_core_done     in   1                 one-cycle result-ready pulse
//  i_core_result   in   N_OUT_OPS*OP_W    result; operand 0 in the MSBs
//  o_busy          out  1                 high in START, BUSY and DRAIN
// BEHAVIOUR
//  - Reset: a single clock, with synchronous active-high reset on i_rst.
//    All outputs are 0 after reset except o_in_ready=1. Counters and operand/result registers are
//    cleared and the state is LOAD. Reset asserted mid-job aborts it; partial input is discarded.
//  - A transfer occurs on valid&&ready. o_out_valid and o_out_data stay stable while !i_out_ready.
//  - States:
//    LOAD : o_in_ready=1. Each accepted word is written into the operand register at position
//           in_cnt (0 = MSW of operand 0), then in_cnt++.
//           After the word with in_cnt==IN_WORDS-1 is accepted: go to START and clear in_cnt.
//    START: o_core_start=1 for exactly one cycle, o_in_ready=0, then go to BUSY.
//    BUSY : o_core_operands held constant. On i_core_done, i_core_result is captured,
//           out_cnt is set to 0, and the state moves to DRAIN.
//    DRAIN: o_out_valid=1 and o_out_data = result word out_cnt (MSW of operand 0 first).
//           On each handshake out_cnt++. The handshake with out_cnt==OUT_WORDS-1 exits to LOAD.
//  - Latency:
//    - last input word accepted at cycle T -> o_core_start high at T+1;
//    - i_core_done at cycle D -> first o_out_valid at D+1;
//    - final output handshake at E -> o_in_ready=1 at E+1.
//  - i_core_done outside BUSY is ignored. i_in_valid outside LOAD is not accepted and its data
//    is not written.
//  - Counter widths are $clog2 of IN_WORDS and OUT_WORDS (minimum 1 bit). They never wrap:
//    each counter is cleared on its state exit.
//  - o_core_operands changes only in LOAD, and only on accepted words.
// CONFIGURATION
//  FRAMER_OVERLAP_EN defined:
//   - o_in_ready is also 1 during DRAIN. The next job is loaded into the operand register while
//     the result drains.
//   - On the final output handshake, if all IN_WORDS are already loaded, the next state is START
//     (not LOAD).
//   - If the final input word and the final output handshake land in the same cycle, both complete
//     and the next state is START.
//  FRAMER_OVERLAP_EN undefined:
//   - o_in_ready=0 in DRAIN; loading is strictly serial with draining, exactly as in LOAD above.
// TESTING
//  1 Defaults, 12 words 1..12 with valid held high -> operands = {1,2,...,12} (word 1 in MSBs);
//    o_core_start high exactly one cycle, on the cycle after word 12 is accepted.
//  2 Core returns result {A,B,C,D} with i_out_ready=1 -> o_out_data A,B,C,D on 4 consecutive
//    cycles, then o_in_ready=1.
//  3 i_out_ready toggled 1,0,0,1,... -> each word held stable while stalled; no word is
//    duplicated or dropped.
//  4 i_rst pulsed after 7 input words -> o_in_ready=1 and o_busy=0 next cycle; a fresh 12 words
//    produce only the new operands.
//  5 i_core_done pulsed in LOAD, and i_in_valid asserted during BUSY -> no state change and
//    operands unchanged.
//  6 FRAMER_OVERLAP_EN, with OP_W=128 and N_IN_OPS=2 -> 4 words loaded during DRAIN;
//    o_core_start fires one cycle after the last output handshake.

Source files
------------

// File: rtl/ecc_io_framer.sv
// Stream framer: packs host words into core operands, pulses start, then streams the result back.
// Define FRAMER_OVERLAP_EN to load the next job while the current result drains.
module ecc_io_framer #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned OP_W      = 256,
    parameter int unsigned N_IN_OPS  = 3,
    parameter int unsigned N_OUT_OPS = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [DATA_W-1:0]         i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [DATA_W-1:0]         o_out_data,
    output logic                      o_core_start,
    output logic [N_IN_OPS*OP_W-1:0]  o_core_operands,
    input  logic                      i_core_done,
    input  logic [N_OUT_OPS*OP_W-1:0] i_core_result,
    output logic                      o_busy
);

    localparam int unsigned WORDS     = OP_W / DATA_W;
    localparam int unsigned IN_WORDS  = N_IN_OPS * WORDS;
    localparam int unsigned OUT_WORDS = N_OUT_OPS * WORDS;
    localparam int unsigned IN_CW     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int unsigned OUT_CW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

`ifdef FRAMER_OVERLAP_EN
    localparam bit OverlapEn = 1'b1;
`else
    localparam bit OverlapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StLoad, StStart, StBusy, StDrain} state_e;

    state_e                          state_q, state_d;
    logic [IN_CW-1:0]                in_cnt_q, in_cnt_d;
    logic [OUT_CW-1:0]               out_cnt_q, out_cnt_d;
    logic                            pend_q, pend_d;
    logic [IN_WORDS-1:0][DATA_W-1:0] op_q;
    logic [OUT_WORDS-1:0][DATA_W-1:0] res_q;

    logic             in_fire, out_fire, in_last, out_last, res_we;
    logic [IN_CW-1:0] in_idx;
    logic [OUT_CW-1:0] out_idx;

    // Word 0 of the stream lands in the most significant slot.
    assign in_idx   = IN_CW'(IN_WORDS - 1) - in_cnt_q;
    assign out_idx  = OUT_CW'(OUT_WORDS - 1) - out_cnt_q;
    assign in_last  = (in_cnt_q == IN_CW'(IN_WORDS - 1));
    assign out_last = (out_cnt_q == OUT_CW'(OUT_WORDS - 1));
    assign in_fire  = i_in_valid && o_in_ready;
    assign out_fire = o_out_valid && i_out_ready;

    always_comb begin
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_core_start = 1'b0;
        o_busy       = 1'b1;
        o_out_data   = '0;
        case (state_q)
            StLoad: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
            end
            StStart: o_core_start = 1'b1;
            StDrain: begin
                // A fully loaded next job blocks input until it has been started.
                o_in_ready  = OverlapEn && !pend_q;
                o_out_valid = 1'b1;
                o_out_data  = res_q[out_idx];
            end
            default: ;
        endcase
    end

    assign o_core_operands = op_q;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        pend_d    = pend_q;
        res_we    = 1'b0;
        if (in_fire) begin
            in_cnt_d = in_last ? '0 : in_cnt_q + 1'b1;
        end
        case (state_q)
            StLoad: begin
                if (in_fire && in_last) state_d = StStart;
            end
            StStart: begin
                pend_d  = 1'b0;
                state_d = StBusy;
            end
            StBusy: begin
                if (i_core_done) begin
                    res_we    = 1'b1;
                    out_cnt_d = '0;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (in_fire && in_last) pend_d = 1'b1;
                if (out_fire) begin
                    if (out_last) begin
                        out_cnt_d = '0;
                        state_d   = (pend_q || (in_fire && in_last)) ? StStart : StLoad;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StLoad;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            pend_q    <= 1'b0;
            op_q      <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            pend_q    <= pend_d;
            if (in_fire) op_q[in_idx] <= i_in_data;
            if (res_we) res_q <= i_core_result;
        end
    end

endmodule

// File: tb/tb_ecc_io_framer.sv
// Randomised self-checking bench for ecc_io_framer: default geometry plus a 2x128-bit instance.
// Overlap expectations follow FRAMER_OVERLAP_EN.
module tb_ecc_io_framer;

`ifdef FRAMER_OVERLAP_EN
    localparam bit Ovl = 1'b1;
`else
    localparam bit Ovl = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, out_valid, out_ready, core_start, core_done, busy;
    logic [63:0]  in_data, out_data;
    logic [767:0] core_operands;
    logic [255:0] core_result;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_core_start, b_core_done;
    logic         b_busy;
    logic [63:0]  b_in_data, b_out_data;
    logic [255:0] b_core_operands;
    logic [127:0] b_core_result;

    ecc_io_framer dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_core_start(core_start), .o_core_operands(core_operands),
        .i_core_done(core_done), .i_core_result(core_result), .o_busy(busy)
    );

    ecc_io_framer #(.DATA_W(64), .OP_W(128), .N_IN_OPS(2), .N_OUT_OPS(1)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
        .o_core_start(b_core_start), .o_core_operands(b_core_operands),
        .i_core_done(b_core_done), .i_core_result(b_core_result), .o_busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0]  job[$];
    logic [255:0] res_exp;
    logic [63:0]  bjob[$];
    logic [127:0] bres;
    logic [255:0] bops_old;
    int           bidx;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [767:0] pack_job();
        logic [767:0] v = '0;
        for (int i = 0; i < 12; i++) v = (v << 64) | 768'(job[i]);
        return v;
    endfunction

    function automatic logic [255:0] pack_bjob();
        logic [255:0] v = '0;
        for (int i = 0; i < 4; i++) v = (v << 64) | 256'(bjob[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_job();
        job.delete();
        for (int i = 0; i < 12; i++) job.push_back(rnd64());
    endtask

    task automatic load_job(input bit gaps);
        int idx = 0, guard = 0, early = 0;
        bit acc;
        while (idx < 12 && guard < 500) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? job[idx] : rnd64();
            if (core_start) early++;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        checks++; if (idx != 12) $display("FAIL load_timeout: got %0d words expected 12", idx);
        if (idx != 12) errors++;
        checks++; if (early != 0) begin
            $display("FAIL early_start: got %0d pulses expected 0", early); errors++;
        end
        checks++; if (core_start !== 1'b1) begin
            $display("FAIL start_pulse: got %b expected 1", core_start); errors++;
        end
        checks++; if (core_operands !== pack_job()) begin
            $display("FAIL operands: got %h expected %h", core_operands, pack_job()); errors++;
        end
        tick();
        checks++; if (core_start !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL start_width: got start=%b busy=%b expected 0 1", core_start, busy);
            errors++;
        end
    endtask

    task automatic core_finish(input int delay);
        repeat (delay) tick();
        core_done   = 1'b1;
        core_result = res_exp;
        tick();
        core_done   = 1'b0;
        core_result = {rnd64(), rnd64(), rnd64(), rnd64()};
        checks++; if (out_valid !== 1'b1) begin
            $display("FAIL done_latency: got valid=%b expected 1", out_valid); errors++;
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic drain(input int mode);
        logic [63:0] exp_w[$];
        int k = 0, cyc = 0;
        bit fire;
        for (int i = 3; i >= 0; i--) exp_w.push_back(res_exp[i*64 +: 64]);
        while (k < 4 && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 3) == 0)
                                                         : 1'($urandom_range(0, 1));
            checks++; if (out_valid !== 1'b1 || out_data !== exp_w[k]) begin
                $display("FAIL drain_word%0d: got v=%b %h expected v=1 %h",
                         k, out_valid, out_data, exp_w[k]);
                errors++;
            end
            checks++; if (in_ready !== Ovl) begin
                $display("FAIL drain_in_ready: got %b expected %b", in_ready, Ovl); errors++;
            end
            fire = out_ready;
            tick();
            if (fire) k++;
            cyc++;
        end
        out_ready = 1'b0;
        checks++; if (k != 4 || (mode == 0 && cyc != 4)) begin
            $display("FAIL drain_count: got %0d words in %0d cycles expected 4", k, cyc); errors++;
        end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL drain_exit: got rdy=%b busy=%b v=%b expected 1 0 0",
                     in_ready, busy, out_valid);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_start !== 1'b0 ||
                      busy !== 1'b0 || out_data !== 64'h0 || core_operands !== '0) begin
            $display("FAIL reset_state: got rdy=%b v=%b st=%b busy=%b expected 1 0 0 0",
                     in_ready, out_valid, core_start, busy);
            errors++;
        end
        checks++; if (b_in_ready !== 1'b1 || b_busy !== 1'b0 || b_core_operands !== '0) begin
            $display("FAIL reset_state_b: got rdy=%b busy=%b expected 1 0", b_in_ready, b_busy);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_load_drain();
        job.delete();
        for (int i = 1; i <= 12; i++) job.push_back(64'(i));
        load_job(1'b0);
        res_exp = {rnd64(), rnd64(), rnd64(), rnd64()};
        core_finish(0);
        drain(0);
    endtask

    task automatic test_backpressure();
        for (int m = 1; m <= 2; m++) begin
            new_job();
            load_job(1'b1);
            res_exp = {rnd64(), rnd64(), rnd64(), rnd64()};
            core_finish($urandom_range(0, 3));
            drain(m);
        end
    endtask

    task automatic test_reset_mid();
        new_job();
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = job[i];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || core_operands !== '0) begin
            $display("FAIL mid_reset: got rdy=%b busy=%b expected 1 0", in_ready, busy);
            errors++;
        end
        new_job();
        load_job(1'b0);
        res_exp = {rnd64(), rnd64(), rnd64(), rnd64()};
        core_finish(1);
        drain(0);
    endtask

    task automatic test_ignore();
        core_done   = 1'b1;
        core_result = {rnd64(), rnd64(), rnd64(), rnd64()};
        tick();
        core_done = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL done_in_load: got busy=%b v=%b rdy=%b expected 0 0 1",
                     busy, out_valid, in_ready);
            errors++;
        end
        new_job();
        load_job(1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = rnd64();
            tick();
            checks++; if (in_ready !== 1'b0 || core_operands !== pack_job() ||
                          busy !== 1'b1 || core_start !== 1'b0) begin
                $display("FAIL valid_in_busy: got rdy=%b busy=%b ops=%h expected 0 1 %h",
                         in_ready, busy, core_operands, pack_job());
                errors++;
            end
        end
        in_valid = 1'b0;
        res_exp  = {rnd64(), rnd64(), rnd64(), rnd64()};
        core_finish(0);
        drain(2);
    endtask

    task automatic b_new_job();
        bops_old = pack_bjob();
        bjob.delete();
        for (int i = 0; i < 4; i++) bjob.push_back(rnd64());
        bidx = 0;
    endtask

    task automatic b_load_rest();
        int guard = 0;
        bit acc;
        while (bidx < 4 && guard < 100) begin
            b_in_valid = 1'b1;
            b_in_data  = bjob[bidx];
            acc = b_in_ready;
            tick();
            if (acc) bidx++;
            guard++;
        end
        b_in_valid = 1'b0;
        checks++; if (bidx != 4 || b_core_start !== 1'b1 || b_core_operands !== pack_bjob()) begin
            $display("FAIL b_start: got n=%0d st=%b ops=%h expected 4 1 %h",
                     bidx, b_core_start, b_core_operands, pack_bjob());
            errors++;
        end
        tick();
        checks++; if (b_core_start !== 1'b0 || b_busy !== 1'b1) begin
            $display("FAIL b_start_width: got st=%b busy=%b expected 0 1", b_core_start, b_busy);
            errors++;
        end
    endtask

    task automatic b_core();
        repeat ($urandom_range(0, 2)) tick();
        bres          = {rnd64(), rnd64()};
        b_core_done   = 1'b1;
        b_core_result = bres;
        tick();
        b_core_done   = 1'b0;
        b_core_result = {rnd64(), rnd64()};
        checks++; if (b_out_valid !== 1'b1) begin
            $display("FAIL b_done_latency: got %b expected 1", b_out_valid); errors++;
        end
    endtask

    // Per-cycle schedule: bit c of ivs/ors drives input valid / output ready on drain cycle c.
    task automatic b_drain_sched(input logic [7:0] ivs, input logic [7:0] ors, input int n);
        logic [63:0] bout[2];
        int k = 0;
        bit exp_rdy, acc, fire;
        bout[0] = bres[127:64];
        bout[1] = bres[63:0];
        for (int c = 0; c < n; c++) begin
            b_in_valid  = ivs[c];
            b_in_data   = (bidx < 4) ? bjob[bidx] : rnd64();
            b_out_ready = ors[c];
            exp_rdy     = Ovl && (bidx < 4);
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== bout[k]) begin
                $display("FAIL b_drain_word%0d: got v=%b %h expected v=1 %h",
                         k, b_out_valid, b_out_data, bout[k]);
                errors++;
            end
            checks++; if (b_in_ready !== exp_rdy) begin
                $display("FAIL b_drain_in_ready: cycle %0d got %b expected %b",
                         c, b_in_ready, exp_rdy);
                errors++;
            end
            acc  = ivs[c] && exp_rdy;
            fire = ors[c];
            tick();
            if (acc) bidx++;
            if (fire) k++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        checks++; if (b_out_valid !== 1'b0 || b_busy !== (bidx == 4) ||
                      b_core_start !== (bidx == 4) || b_in_ready !== (bidx != 4)) begin
            $display("FAIL b_drain_exit: got v=%b busy=%b st=%b rdy=%b loaded=%0d",
                     b_out_valid, b_busy, b_core_start, b_in_ready, bidx);
            errors++;
        end
        if (bidx == 0) begin
            checks++; if (b_core_operands !== bops_old) begin
                $display("FAIL b_ops_held: got %h expected %h", b_core_operands, bops_old);
                errors++;
            end
        end
    endtask

    task automatic test_overlap();
        bjob.delete();
        for (int i = 0; i < 4; i++) bjob.push_back(64'h0);
        b_new_job();
        b_load_rest();
        b_core();
        b_new_job();
        b_drain_sched(8'b0001_1111, 8'b0110_0000, 7);
        b_load_rest();
        b_core();
        b_new_job();
        b_drain_sched(8'b0001_0111, 8'b0001_1000, 5);
        b_load_rest();
        b_core();
        b_new_job();
        b_drain_sched(8'b0000_0000, 8'b0000_0011, 2);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_done = 1'b0; core_result = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_core_done = 1'b0;
        b_core_result = '0;
        test_reset();
        test_load_drain();
        test_backpressure();
        test_reset_mid();
        test_ignore();
        test_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
